// File: rtl/bcd_counter_display.sv
// Four-digit BCD event counter with a multiplexed
// active-low seven-segment scan driver.
module bcd_counter_display #(
  parameter logic [15:0] SCAN_MAX = 16'd20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic        clr,
  output logic [15:0] cnt_val,
  output logic        carry,
  output logic [3:0]  led_en,
  output logic [7:0]  led_seg
);

  logic [15:0] cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic [15:0] scan_q, scan_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  en_q, en_d;
  logic [7:0]  seg_q, seg_d;

  logic [15:0] inc;
  logic        wrap;
  logic [3:0]  dig;

  function automatic logic [7:0] seg_of(
    input logic [3:0] d
  );
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Ripple increment: a 9 rolls to 0 and
  // passes the carry on to the next digit.
  always_comb begin
    logic c;
    inc = cnt_q;
    c   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c && cnt_q[4*i +: 4] == 4'd9) begin
        inc[4*i +: 4] = 4'd0;
      end else begin
        inc[4*i +: 4] = cnt_q[4*i +: 4]
                      + {3'b000, c};
        c = 1'b0;
      end
    end
    wrap = c;
  end

  assign dig = cnt_q[{sel_q, 2'b00} +: 4];

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    if (clr) begin
      cnt_d = 16'h0000;
    end else if (update) begin
      cnt_d   = inc;
      carry_d = wrap;
    end
  end

  always_comb begin
    scan_d = scan_q + 16'd1;
    sel_d  = sel_q;
    if (scan_q == SCAN_MAX - 16'd1) begin
      scan_d = 16'd0;
      sel_d  = sel_q + 2'd1;
    end
    en_d  = ~(4'b0001 << sel_q);
    seg_d = seg_of(dig);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 16'h0000;
      carry_q <= 1'b0;
      scan_q  <= 16'd0;
      sel_q   <= 2'd0;
      en_q    <= 4'hF;
      seg_q   <= 8'hFF;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      seg_q   <= seg_d;
    end
  end

  assign cnt_val = cnt_q;
  assign carry   = carry_q;
  assign led_en  = en_q;
  assign led_seg = seg_q;

endmodule

// File: doc/bcd_counter_display.md
# bcd_counter_display

Four-digit decimal event counter with an integrated seven-segment scan driver. It sits directly downstream of the controlled clock counter and consumes that block's single-cycle `update` pulse, advancing a BCD count 0000–9999 once per pulse. It time-multiplexes the count onto a four-digit, active-low common-anode display, and exposes the raw BCD value and a wrap pulse for cascading.

## Interface
- `SCAN_MAX`, default 20000: clock cycles each digit is enabled per scan step. Legal range is ≥2; width is 16 bits.
- `clk`  in  1  system clock. All state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset. It is sampled on the rising edge of `clk` and overrides every other input.
- `update`  in  1  count-enable pulse, normally one cycle wide. The count increments once per cycle in which `update` is high.
- `clr`  in  1  synchronous clear of the count only. The scan state is unaffected.
- `cnt_val`  out  16  registered BCD count `{d3,d2,d1,d0}`; d0 is the least significant digit.
- `carry`  out  1  registered one-cycle pulse on a wrap from 9999 to 0000.
- `led_en`  out  4  registered digit enables, active low. Bit i selects digit i.
- `led_seg`  out  8  registered segment lines, active low, ordered `{DP,G,F,E,D,C,B,A}`.

## Operation
- **Count update.** On each edge, priority is `rst` > `clr` > `update`.
  - `rst`: `cnt_val`=16'h0000 and `carry`=0.
  - `clr` (rst low): `cnt_val`=0 and `carry`=0, regardless of `update`.
  - `update` high (rst and clr low): BCD increment with per-digit ripple.
    - A digit equal to 9 becomes 0 and carries into the next digit.
    - 9999 becomes 0000 and `carry`=1 for that cycle only.
  - Otherwise the count holds and `carry`=0.
- **BCD digits.** Each digit stays in 0–9 at all times; no binary-to-BCD conversion is used.
- **Scan counter** `scan_cnt`, 16 bits, counts 0..SCAN_MAX-1.
  - At SCAN_MAX-1 it returns to 0 and digit index `sel` (2 bits) advances: 0→1→2→3→0.
  - `rst` sets `scan_cnt`=0 and `sel`=0. `clr` and `update` never touch the scan state.
- **Display registers.** Each non-reset edge loads the following:
  - `led_en` = one-cold pattern for the current `sel`: 1110, 1101, 1011, 0111.
  - `led_seg` = decode of digit `sel` of the current `cnt_val`. DP is always 1 (off).
- **Decode, active low.** 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Codes A–F cannot occur. If forced, they decode to FF (blank).
- **Leading zeros.** Leading zeros are displayed; there is no blanking.

## Timing
- **Reset values.** `cnt_val`=0000, `carry`=0, `led_en`=4'hF (all off), `led_seg`=8'hFF.
- **Count latency.** `update` high at edge k gives the new `cnt_val` visible after edge k.
  - `carry` rises at the same edge as the wrap to 0000 and falls at the next edge.
- **Back-to-back updates.** `update` held high for N cycles increments the count N times.
- **Display latency.** One cycle behind `sel` and `cnt_val`.
  - A count change at edge k appears on `led_seg` after edge k+1, when its digit is selected.
- **First valid frame.** The first edge with `rst` low loads `led_en`=1110 and `led_seg`=decode(d0).
- **Digit dwell.** Each digit is enabled for exactly SCAN_MAX consecutive cycles. A full frame is 4·SCAN_MAX cycles.
  - The enable transition coincides with the `led_seg` transition, because both come from the same register stage. There is no ghost cycle.
- **Reset mid-operation.** The count, scan and outputs return to their reset values at that edge.
  - The next frame restarts at digit 0 with a full SCAN_MAX dwell.
- **`clr` with `update`.** If both are high on the same edge, the count is 0000 and `carry`=0.

## Test plan
- **Reset.** Hold `rst` 3 cycles, then release.
  - During reset: `cnt_val`=0000, `carry`=0, `led_en`=F, `led_seg`=FF.
  - One edge after release: `led_en`=E, `led_seg`=C0.
- **Counting.** Apply 10 single-cycle `update` pulses 5 cycles apart → `cnt_val`=0x0010.
  - Then hold `update` high 90 cycles → `cnt_val`=0x0100.
- **Wrap.** Preload the count to 0x9998 by pulsing, then apply 2 pulses.
  - First pulse → `cnt_val`=9999 and `carry`=0.
  - Second pulse → `cnt_val`=0000 with `carry`=1 for exactly 1 cycle.
- **Clear priority.** At `cnt_val`=0x0123, assert `clr` and `update` on the same edge → `cnt_val`=0000 and `carry`=0.
  - Scan phase and `led_en` sequence continue uninterrupted.
- **Scan sequence.** With SCAN_MAX=4 and `cnt_val`=0x4321, `led_en`/`led_seg` cycle through:
  - E/F9, then D/A4, then B/B0, then 7/99, each held exactly 4 cycles, repeating with period 16.
- **Reset mid-frame.** Assert `rst` while `sel`=2 and `cnt_val`=0x0057.
  - Next edge gives reset values. After release, digit 0 shows C0 for a full 4 cycles with SCAN_MAX=4.
